fetch_issue_unit: RTL

Front-end instruction fetch stage that produces the opcode stream consumed by the control/decode block. Holds the PC, fetches 32-bit instruction words from instruction memory over a req/ready handshake, and issues them to decode over a valid/ready handshake. Accepts PC redirects for taken branches and jumps back from the execute side. Exports the PC of each issued instruction so SavePC has a source operand.

---
 rtl/fetch_issue_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_issue_unit.sv
// Instruction fetch/issue front end: PC, imem req/ready fetch and decode valid/ready issue.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt performance counter.
module fetch_issue_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] PC_INC   = PC_W'(1)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  output logic            inst_valid,
  input  logic            dec_ready,
  output logic [31:0]     inst,
  output logic [3:0]      opcode,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic [PC_W-1:0] inst_pc
);

  typedef enum logic [1:0] {
    S_LAUNCH = 2'd0,
    S_WAIT   = 2'd1,
    S_ISSUE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic            vld_q, vld_d;
  logic            kill_q, kill_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LAUNCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      vld_q     <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      vld_q     <= vld_d;
      kill_q    <= kill_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    vld_d     = vld_q;
    kill_d    = kill_q;
    unique case (state_q)
      S_LAUNCH: begin
        // A redirect here steers the launch itself, so nothing needs killing.
        req_d   = 1'b1;
        addr_d  = redirect_valid ? redirect_target : pc_q;
        pc_d    = addr_d;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ready) begin
          req_d   = 1'b0;
          kill_d  = 1'b0;
          state_d = S_LAUNCH;
          if (redirect_valid) begin
            pc_d = redirect_target;
          end else if (!kill_q) begin
            inst_d    = imem_rdata;
            inst_pc_d = addr_q;
            pc_d      = addr_q + PC_INC;
            vld_d     = 1'b1;
            state_d   = S_ISSUE;
          end
        end else if (redirect_valid) begin
          // Request cannot be withdrawn; mark its response stale instead.
          pc_d   = redirect_target;
          kill_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (redirect_valid) begin
          vld_d   = 1'b0;
          pc_d    = redirect_target;
          state_d = S_LAUNCH;
        end else if (dec_ready) begin
          vld_d   = 1'b0;
          state_d = S_LAUNCH;
        end
      end
      default: state_d = S_LAUNCH;
    endcase
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stall_inc;

  assign stall_inc = (state_q == S_WAIT) || ((state_q == S_ISSUE) && !dec_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_q <= '0;
    else if (stall_inc && (stall_q != '1))   stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = vld_q;
  assign inst       = inst_q;
  assign opcode     = inst_q[31:28];
  assign inst_pc    = inst_pc_q;

endmodule
